// File: rtl/multi_lockout_pkg.sv
// Shared types and helpers for the multi-channel button lockout one-shot.
// State encoding and counter sizing are common to every channel.
package multi_lockout_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    REL   = 3'd4
  } state_e;

  // One spare bit above the largest terminal count keeps compares unambiguous.
  function automatic int cnt_width(input int deb, input int pls, input int rpt);
    int m;
    m = deb;
    if (pls > m) m = pls;
    if (rpt > m) m = rpt;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/lockout_channel.sv
// One button channel: 2-flop synchroniser, debounce/one-shot FSM and shared counter.
// Outputs are registered from the next-state so they never glitch.
module lockout_channel
  import multi_lockout_pkg::*;
#(
  parameter int DEB_CYCLES    = 4,
  parameter int PULSE_CYCLES  = 2,
  parameter int REPEAT_CYCLES = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic l_n,
  input  logic repeat_en,
  output logic p_n,
  output logic held
);

  localparam int CW = cnt_width(DEB_CYCLES, PULSE_CYCLES, REPEAT_CYCLES);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] PLS_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          p_n_q, p_n_d;
  logic          held_q, held_d;
  logic          s_n;

  assign s_n = sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      p_n_q   <= 1'b1;
      held_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_n_q   <= p_n_d;
      held_q  <= held_d;
    end
  end

  always_comb begin
    sync1_d = l_n;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (!s_n) begin
          state_d = ARM;
          cnt_d   = '0;
        end
      end
      ARM: begin
        if (s_n) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = PULSE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PULSE: begin
        // The pulse always runs to full width; the button is ignored here.
        if (cnt_q == PLS_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (s_n) begin
          state_d = REL;
          cnt_d   = '0;
        end else if (repeat_en && (cnt_q == REP_LAST)) begin
          state_d = PULSE;
          cnt_d   = '0;
        end else if (cnt_q < REP_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REL: begin
        // A low sample while releasing is bounce: back to HOLD without a new pulse.
        if (!s_n) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    p_n_d  = (state_d != PULSE);
    held_d = (state_d == PULSE) || (state_d == HOLD) || (state_d == REL);
  end

  assign p_n  = p_n_q;
  assign held = held_q;

endmodule

// File: rtl/multi_lockout.sv
// Multi-channel lockout one-shot: NUM_CH independent button channels
// sharing a single auto-repeat enable.
module multi_lockout
  import multi_lockout_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int DEB_CYCLES    = 4,
  parameter int PULSE_CYCLES  = 2,
  parameter int REPEAT_CYCLES = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] L_n,
  input  logic              repeat_en,
  output logic [NUM_CH-1:0] P_n,
  output logic [NUM_CH-1:0] held
);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      lockout_channel #(
        .DEB_CYCLES   (DEB_CYCLES),
        .PULSE_CYCLES (PULSE_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
      ) u_ch (
        .clk      (clk),
        .rst_n    (rst_n),
        .l_n      (L_n[gi]),
        .repeat_en(repeat_en),
        .p_n      (P_n[gi]),
        .held     (held[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_multi_lockout.sv
// Bench for multi_lockout: event-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_multi_lockout;

  localparam int N = 4;
  localparam int D = 4;
  localparam int P = 2;
  localparam int R = 10;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] L_n;
  logic         repeat_en;
  logic [N-1:0] P_n;
  logic [N-1:0] held;

  int vectors = 0;
  int miscompares = 0;

  multi_lockout #(
    .NUM_CH(N), .DEB_CYCLES(D), .PULSE_CYCLES(P), .REPEAT_CYCLES(R)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .L_n      (L_n),
    .repeat_en(repeat_en),
    .P_n      (P_n),
    .held     (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts runs of stable synchronised samples and
  // remaining pulse cycles, instead of tracking explicit FSM states.
  int   low_run[N], high_run[N], pulse_left[N], age[N];
  bit   latched[N];
  logic s1[N], s2[N];

  function automatic void model_reset();
    for (int c = 0; c < N; c++) begin
      low_run[c] = 0; high_run[c] = 0; pulse_left[c] = 0; age[c] = 0;
      latched[c] = 1'b0; s1[c] = 1'b1; s2[c] = 1'b1;
    end
  endfunction

  function automatic void model_step();
    for (int c = 0; c < N; c++) begin
      logic s;
      s = s2[c];
      if (pulse_left[c] > 0) begin
        pulse_left[c]--;
        if (pulse_left[c] == 0) begin
          age[c] = 0;
          high_run[c] = 0;
        end
      end else if (!latched[c]) begin
        if (!s) begin
          low_run[c]++;
          if (low_run[c] == D + 1) begin
            latched[c] = 1'b1;
            pulse_left[c] = P;
            low_run[c] = 0;
          end
        end else begin
          low_run[c] = 0;
        end
      end else begin
        if (s) begin
          high_run[c]++;
          if (high_run[c] == D + 1) begin
            latched[c] = 1'b0;
            high_run[c] = 0;
            low_run[c] = 0;
          end
        end else if (high_run[c] > 0) begin
          high_run[c] = 0;
          age[c] = 0;
        end else if (repeat_en && age[c] >= R - 1) begin
          pulse_left[c] = P;
        end else begin
          age[c]++;
        end
      end
      s2[c] = s1[c];
      s1[c] = L_n[c];
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  logic [N-1:0] exp_p, exp_h;
  always @(negedge clk) begin
    for (int c = 0; c < N; c++) begin
      exp_p[c] = (pulse_left[c] > 0) ? 1'b0 : 1'b1;
      exp_h[c] = latched[c];
    end
    chk("model_P_n", 32'(P_n), 32'(exp_p));
    chk("model_held", 32'(held), 32'(exp_h));
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic         pl[64];
  logic         hl[64];
  logic [N-1:0] pv[64];
  int           lows, his, oth;

  initial begin
    rst_n = 1'b0;
    L_n = '1;
    repeat_en = 1'b0;
    tick(3);
    chk("reset_P_n", 32'(P_n), 32'hF);
    chk("reset_held", 32'(held), 32'h0);
    rst_n = 1'b1;
    tick(3);

    // Single press on ch0, no repeat
    L_n[0] = 1'b0;
    oth = 0;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      pl[k] = P_n[0];
      hl[k] = held[0];
      if (P_n[3:1] != 3'b111 || held[3:1] != 3'b000) oth++;
      if (k == 19) L_n[0] = 1'b1;
    end
    lows = 0;
    for (int k = 0; k < 30; k++) if (!pl[k]) lows++;
    chk("t1_p5", 32'(pl[5]), 32'd1);
    chk("t1_p6", 32'(pl[6]), 32'd0);
    chk("t1_p7", 32'(pl[7]), 32'd0);
    chk("t1_p8", 32'(pl[8]), 32'd1);
    chk("t1_low_count", 32'(lows), 32'd2);
    chk("t1_h5", 32'(hl[5]), 32'd0);
    chk("t1_h6", 32'(hl[6]), 32'd1);
    chk("t1_h29", 32'(hl[29]), 32'd0);
    chk("t1_others_idle", 32'(oth), 32'd0);
    tick(2);

    // Short 3-cycle press on ch1: rejected by debounce
    L_n[1] = 1'b0;
    lows = 0; his = 0;
    for (int k = 0; k < 15; k++) begin
      tick(1);
      if (k == 2) L_n[1] = 1'b1;
      if (!P_n[1]) lows++;
      if (held[1]) his++;
    end
    chk("t2_no_pulse", 32'(lows), 32'd0);
    chk("t2_no_held", 32'(his), 32'd0);

    // Auto-repeat on ch2
    repeat_en = 1'b1;
    L_n[2] = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick(1);
      pl[k] = P_n[2];
      hl[k] = held[2];
      if (k == 37) L_n[2] = 1'b1;
    end
    for (int k = 0; k < 50; k++) begin
      logic e;
      e = (k == 6 || k == 7 || k == 18 || k == 19 || k == 30 || k == 31) ? 1'b0 : 1'b1;
      chk($sformatf("t3_p%0d", k), 32'(pl[k]), 32'(e));
    end
    chk("t3_h42", 32'(hl[42]), 32'd1);
    chk("t3_h44", 32'(hl[44]), 32'd0);
    repeat_en = 1'b0;
    tick(2);

    // Release bounce on ch0: REL falls back to HOLD, no new pulse
    L_n[0] = 1'b0;
    tick(12);
    chk("t4_held_before", 32'(held[0]), 32'd1);
    L_n[0] = 1'b1;
    lows = 0; his = 0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (k == 1) L_n[0] = 1'b0;
      if (!P_n[0]) lows++;
      if (!held[0]) his++;
    end
    chk("t4_no_pulse", 32'(lows), 32'd0);
    chk("t4_held_kept", 32'(his), 32'd0);
    L_n[0] = 1'b1;
    tick(10);
    chk("t4_released", 32'(held[0]), 32'd0);

    // All channels pressed together
    L_n = '0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      pv[k] = P_n;
    end
    chk("t5_p5", 32'(pv[5]), 32'hF);
    chk("t5_p6", 32'(pv[6]), 32'h0);
    chk("t5_p7", 32'(pv[7]), 32'h0);
    chk("t5_p8", 32'(pv[8]), 32'hF);
    L_n = '1;
    tick(10);

    // Reset in mid-pulse on ch3
    L_n[3] = 1'b0;
    tick(7);
    chk("t6_pulse_low", 32'(P_n[3]), 32'd0);
    rst_n = 1'b0;
    L_n[3] = 1'b1;
    #1;
    chk("t6_rst_P_n", 32'(P_n[3]), 32'd1);
    chk("t6_rst_held", 32'(held[3]), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    lows = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (!P_n[3]) lows++;
    end
    chk("t6_no_pulse_after_rst", 32'(lows), 32'd0);
    L_n[3] = 1'b0;
    tick(6);
    chk("t6_repress_p5", 32'(P_n[3]), 32'd1);
    tick(1);
    chk("t6_repress_p6", 32'(P_n[3]), 32'd0);
    tick(1);
    chk("t6_repress_p7", 32'(P_n[3]), 32'd0);
    tick(1);
    chk("t6_repress_p8", 32'(P_n[3]), 32'd1);
    L_n[3] = 1'b1;
    tick(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multi_lockout.md
Name: multi_lockout

Overview:
- Parametrised, multi-channel successor to the single-button lockout one-shot.
- Each channel takes an active-low raw button level and synchronises and debounces it.
- Each valid press produces one active-low output pulse of programmable width, then locks out until a debounced release.
- Optional auto-repeat re-fires the pulse while the button stays held. Sits between the board push-buttons and the control logic.

Parameters:
- NUM_CH, 4, number of independent channels.
- DEB_CYCLES, 4, consecutive stable synchronised samples needed to accept a press or a release (>=1).
- PULSE_CYCLES, 2, width of each P_n low pulse in clk cycles (>=1).
- REPEAT_CYCLES, 10, cycles from end of a pulse to the next auto-repeat pulse while held (>=1).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- L_n  in  NUM_CH  raw button levels, active low, asynchronous to clk.
- repeat_en  in  1  global auto-repeat enable, sampled every cycle.
- P_n  out  NUM_CH  registered one-shot outputs, active low.
- held  out  NUM_CH  registered debounced "pressed" status, active high.

Behaviour:
- Reset (async, rst_n=0):
  - P_n all 1, held all 0.
  - Every channel in IDLE, counters 0.
  - Synchroniser flops forced to 1 (released).
  - Reset asserted mid-pulse forces P_n high immediately.
  - After deassertion no pulse fires unless a full new press is seen.
- Synchronisation: 2-flop synchroniser per channel gives s_n. The FSM acts only on s_n.
- Per-channel counter: width clog2(max(DEB_CYCLES, PULSE_CYCLES, REPEAT_CYCLES))+1, unsigned. It never wraps; every terminal compare resets it to 0.
- States and transitions, per channel:
  - IDLE (P_n=1, held=0): s_n=0 -> ARM, cnt=0.
  - ARM (P_n=1, held=0): s_n=1 -> IDLE. Else cnt==DEB_CYCLES-1 -> PULSE, cnt=0. Else cnt+1.
  - PULSE (P_n=0, held=1): cnt==PULSE_CYCLES-1 -> HOLD, cnt=0. Else cnt+1. Full width is always completed, even if the button is released mid-pulse.
  - HOLD (P_n=1, held=1):
    - s_n=1 -> REL, cnt=0.
    - Else repeat_en=1 and cnt==REPEAT_CYCLES-1 -> PULSE, cnt=0.
    - Else cnt+1, saturating at REPEAT_CYCLES-1.
  - REL (P_n=1, held=1): s_n=0 -> HOLD, cnt=0 (bounce on release; no new pulse). Else cnt==DEB_CYCLES-1 -> IDLE. Else cnt+1.
- Latency: edge 0 is the first rising edge that samples L_n low. P_n falls after edge DEB_CYCLES+2 and stays low exactly PULSE_CYCLES cycles.
- Auto-repeat period: PULSE_CYCLES+REPEAT_CYCLES.
- repeat_en changes take effect on the next HOLD evaluation.
- Output registration: P_n and held are decoded from the registered state, so they are glitch-free.
- Channel independence: channels are fully independent. Simultaneous presses on any subset produce simultaneous pulses.
- Illegal state encoding: goes to IDLE on the next edge with P_n=1.

Decomposition:
- Package multi_lockout_pkg holds:
  - state encoding constants IDLE, ARM, PULSE, HOLD, REL (3-bit);
  - a counter-width function.
- Sub-module lockout_channel contains the synchroniser, FSM and counter for one channel.
- multi_lockout instantiates NUM_CH copies in a generate loop and shares repeat_en.

Test Plan:
- Defaults, repeat_en=0, L_n[0] low for 20 cycles from edge 0 -> P_n[0]=0 after edges 6 and 7 only. held[0] rises after edge 6. No second pulse. Other channels stay idle.
- L_n[1] low for 3 cycles, then high -> no pulse; held[1] stays 0.
- repeat_en=1, L_n[2] low from edge 0, high from edge 38 -> pulses begin after edges 6, 18, 30 (each 2 cycles), and no pulse at 42.
- After a press on ch0, release with a 2-cycle high glitch, then low again for 10 cycles -> REL returns to HOLD, no new pulse, held[0] stays 1.
- All four L_n fall on the same cycle -> all four P_n low together after edge 6, identical widths.
- rst_n pulsed low for 1 cycle while P_n[3]=0 -> P_n[3]=1 and held[3]=0 immediately. No pulse afterwards until L_n[3] is released and pressed again.
